// File: rtl/fifo_pack_reader.sv
// rtl/fifo_pack_reader.sv - packs RATIO show-ahead FIFO words into one valid/ready beat
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_fifo_data       FIFO head word (valid while i_fifo_empty=0)
//   i_fifo_empty      FIFO empty flag
//   o_fifo_rd_en      pop strobe, FIFO advances on the edge where it is high
//   i_flush           single-cycle request to emit a partially filled beat
//   o_data            packed beat, first-popped word in the low bits
//   o_count           number of valid words in o_data
//   o_valid, i_ready  output stream handshake
module fifo_pack_reader #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4,
    localparam int CW = $clog2(RATIO) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH-1:0]       i_fifo_data,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_rd_en,
    input  logic                   i_flush,
    output logic [WIDTH*RATIO-1:0] o_data,
    output logic [CW-1:0]          o_count,
    output logic                   o_valid,
    input  logic                   i_ready
);

    localparam int IW = $clog2(RATIO);
    localparam int BW = WIDTH * RATIO;

    logic [BW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          flush_q, flush_d;
    logic [BW-1:0] data_q, data_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;

    logic          out_free;
    logic          at_last;
    logic          rd_en;
    logic          flush_now;
    logic [BW-1:0] merged;

    assign out_free  = !valid_q || i_ready;
    assign at_last   = (idx_q == IW'(RATIO - 1));
    // The completing pop must wait for a free output register; earlier pops
    // only fill the accumulator and may proceed under backpressure.
    assign rd_en     = !i_rst && !i_fifo_empty && !(at_last && !out_free);
    assign flush_now = flush_q && out_free;

    assign o_fifo_rd_en = rd_en;
    assign o_data       = data_q;
    assign o_count      = count_q;
    assign o_valid      = valid_q;

    // Accumulator contents including the word popped this cycle.
    always_comb begin
        merged = acc_q;
        for (int s = 0; s < RATIO; s++) begin
            if (rd_en && idx_q == IW'(s)) begin
                merged[s*WIDTH +: WIDTH] = i_fifo_data;
            end
        end
    end

    always_comb begin
        acc_d   = acc_q;
        idx_d   = idx_q;
        data_d  = data_q;
        count_d = count_q;
        valid_d = valid_q;
        // A pending flush absorbs further requests until it is serviced.
        flush_d = flush_q ? !out_free : i_flush;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (rd_en && at_last) begin
            data_d  = merged;
            count_d = CW'(RATIO);
            valid_d = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
        end else if (flush_now) begin
            if (rd_en) begin
                data_d  = merged;
                count_d = CW'({1'b0, idx_q}) + CW'(1);
                valid_d = 1'b1;
            end else if (idx_q != '0) begin
                data_d  = acc_q;
                count_d = CW'({1'b0, idx_q});
                valid_d = 1'b1;
            end
            acc_d = '0;
            idx_d = '0;
        end else if (rd_en) begin
            acc_d = merged;
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q   <= '0;
            idx_q   <= '0;
            flush_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// tb/tb_fifo_pack_reader.sv - self-checking bench for fifo_pack_reader
module tb_fifo_pack_reader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_rd_en;
    logic        i_flush = 1'b0;
    logic [15:0] o_data;
    logic [2:0]  o_count;
    logic        o_valid;
    logic        i_ready = 1'b0;

    // Show-ahead FIFO model
    logic [3:0] mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;

    assign i_fifo_empty = (wp == rp);
    assign i_fifo_data  = mem[rp];

    int nvec = 0;
    int nerr = 0;

    logic [15:0] got_data [$];
    logic [2:0]  got_cnt  [$];
    logic [3:0]  sent     [$];

    logic        chk_hold = 1'b0;
    logic        hold_q   = 1'b0;
    logic [15:0] hold_data;
    logic [2:0]  hold_cnt;

    fifo_pack_reader #(.WIDTH(4), .RATIO(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_flush      (i_flush),
        .o_data       (o_data),
        .o_count      (o_count),
        .o_valid      (o_valid),
        .i_ready      (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic push(input logic [3:0] w);
        mem[wp] = w;
        wp = wp + 8'd1;
    endtask

    // Settle, sample, cross one rising edge, advance the FIFO model.
    task automatic tick();
        logic rd;
        #1;
        rd = o_fifo_rd_en;
        nvec++;
        if (rd && i_fifo_empty) begin
            nerr++;
            $display("FAIL pop_when_empty: rd_en=%0b empty=%0b, required rd_en=0", rd, i_fifo_empty);
        end
        if (chk_hold) begin
            if (hold_q) begin
                nvec++;
                if (o_valid !== 1'b1 || o_data !== hold_data || o_count !== hold_cnt) begin
                    nerr++;
                    $display("FAIL hold_stable: got v=%0b d=%h c=%0d, required v=1 d=%h c=%0d",
                             o_valid, o_data, o_count, hold_data, hold_cnt);
                end
            end
            hold_q    = o_valid && !i_ready;
            hold_data = o_data;
            hold_cnt  = o_count;
        end
        if (o_valid && i_ready) begin
            got_data.push_back(o_data);
            got_cnt.push_back(o_count);
        end
        @(posedge i_clk);
        #1;
        if (rd) rp = rp + 8'd1;
        #1;
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        wp      = rp;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
    endtask

    task automatic check_beat(input string name, input logic v, input logic [15:0] d, input logic [2:0] c);
        nvec++;
        if (o_valid !== v || (v && (o_data !== d || o_count !== c))) begin
            nerr++;
            $display("FAIL %s: got v=%0b d=%h c=%0d, required v=%0b d=%h c=%0d",
                     name, o_valid, o_data, o_count, v, d, c);
        end
    endtask

    task automatic check_rd(input string name, input logic exp);
        nvec++;
        if (o_fifo_rd_en !== exp) begin
            nerr++;
            $display("FAIL %s: rd_en=%0b, required %0b", name, o_fifo_rd_en, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 1; i <= 4; i++) push(4'(i));
        repeat (4) tick();
        check_beat("reset_preload", 1'b1, 16'h4321, 3'd4);
        push(4'd5);
        #2;
        i_rst = 1'b1;
        #1;
        nvec++;
        if (o_valid !== 1'b0 || o_data !== 16'h0 || o_count !== 3'd0) begin
            nerr++;
            $display("FAIL reset_async: got v=%0b d=%h c=%0d, required all 0", o_valid, o_data, o_count);
        end
        check_rd("reset_rd_en", 1'b0);
        wp = rp;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        check_beat("reset_release", 1'b0, 16'h0, 3'd0);
    endtask

    task automatic test_basic_pack();
        do_reset();
        i_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'(i));
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rd("basic_pop", 1'b1);
            tick();
        end
        check_beat("basic_beat", 1'b1, 16'h4321, 3'd4);
        check_rd("basic_no_pop_empty", 1'b0);
        tick();
        check_beat("basic_accepted", 1'b0, 16'h0, 3'd0);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 1; i <= 8; i++) push(4'(i));
        repeat (4) tick();
        check_beat("bp_first", 1'b1, 16'h4321, 3'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_rd("bp_fill_pop", 1'b1);
            tick();
            check_beat("bp_held", 1'b1, 16'h4321, 3'd4);
        end
        repeat (2) begin
            #1;
            check_rd("bp_stall", 1'b0);
            tick();
            check_beat("bp_held_stall", 1'b1, 16'h4321, 3'd4);
        end
        i_ready = 1'b1;
        #1;
        check_rd("bp_release_pop", 1'b1);
        tick();
        check_beat("bp_second", 1'b1, 16'h8765, 3'd4);
        nvec++;
        if (got_data.size() == 0 || got_data[got_data.size()-1] !== 16'h4321) begin
            nerr++;
            $display("FAIL bp_accept: first beat not accepted on release edge, required 4321");
        end
        tick();
        check_beat("bp_drained", 1'b0, 16'h0, 3'd0);
    endtask

    task automatic test_flush_partial();
        do_reset();
        i_ready = 1'b1;
        push(4'hA);
        push(4'hB);
        repeat (2) tick();
        check_beat("fp_before", 1'b0, 16'h0, 3'd0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        check_beat("fp_beat", 1'b1, 16'h00BA, 3'd2);
        for (int i = 1; i <= 4; i++) push(4'(i));
        repeat (4) tick();
        check_beat("fp_after", 1'b1, 16'h4321, 3'd4);
    endtask

    task automatic test_flush_with_pop();
        do_reset();
        i_ready = 1'b1;
        push(4'd5);
        tick();
        push(4'd6);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        check_beat("fwp_beat", 1'b1, 16'h0065, 3'd2);
    endtask

    task automatic test_flush_empty();
        do_reset();
        i_ready = 1'b1;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (3) begin
            tick();
            check_beat("fe_no_beat", 1'b0, 16'h0, 3'd0);
        end
        for (int i = 1; i <= 4; i++) push(4'(i));
        repeat (4) tick();
        check_beat("fe_after", 1'b1, 16'h4321, 3'd4);
    endtask

    task automatic test_random();
        logic [3:0]  w;
        logic [15:0] exp_d;
        int          exp_c;
        int          nexp;
        int          guard;
        do_reset();
        got_data.delete();
        got_cnt.delete();
        sent.delete();
        hold_q   = 1'b0;
        chk_hold = 1'b1;
        repeat (1500) begin
            if ($urandom_range(0, 3) != 0 && 8'(wp - rp) < 8'd64) begin
                w = 4'($urandom);
                push(w);
                sent.push_back(w);
            end
            i_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        i_ready = 1'b1;
        guard = 0;
        while (wp != rp && guard < 500) begin
            tick();
            guard++;
        end
        nvec++;
        if (guard >= 500) begin
            nerr++;
            $display("FAIL rnd_drain: FIFO not drained within 500 cycles, %0d words left", 8'(wp - rp));
        end
        repeat (2) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (3) tick();
        chk_hold = 1'b0;

        nexp = (sent.size() + 3) / 4;
        nvec++;
        if (got_data.size() != nexp) begin
            nerr++;
            $display("FAIL rnd_beat_count: got %0d beats, required %0d", got_data.size(), nexp);
        end
        for (int i = 0; i < got_data.size() && i < nexp; i++) begin
            exp_d = 16'h0;
            exp_c = 0;
            for (int j = 0; j < 4; j++) begin
                if (i*4 + j < sent.size()) begin
                    exp_d[j*4 +: 4] = sent[i*4 + j];
                    exp_c++;
                end
            end
            nvec++;
            if (got_data[i] !== exp_d || got_cnt[i] !== 3'(exp_c)) begin
                nerr++;
                $display("FAIL rnd_beat[%0d]: got d=%h c=%0d, required d=%h c=%0d",
                         i, got_data[i], got_cnt[i], exp_d, exp_c);
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_flush_partial();
        test_flush_with_pop();
        test_flush_empty();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
